// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the memory / write-back pipeline stage.
package mem_wb_stage_pkg;

  localparam int unsigned DW_DEFAULT  = 16;
  localparam int unsigned AW_DEFAULT  = 3;
  localparam int unsigned TMO_DEFAULT = 15;

  // MEM_signals_in = {memRead, memWrite, memAddress, memData}
  localparam int unsigned MEM_SIG_W     = 4;
  localparam int unsigned MEM_READ_BIT  = 3;
  localparam int unsigned MEM_WRITE_BIT = 2;
  localparam int unsigned MEM_ADDR_BIT  = 1;
  localparam int unsigned MEM_DATA_BIT  = 0;

  // WB_signals_in = {regWrite, WBsel[1:0]}
  localparam int unsigned WB_SIG_W        = 3;
  localparam int unsigned WB_REGWRITE_BIT = 2;
  localparam int unsigned WB_SEL_HI       = 1;
  localparam int unsigned WB_SEL_LO       = 0;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_MEM  = 2'b01,
    WB_SEL_IMM  = 2'b10,
    WB_SEL_RDST = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    WB       = 2'd2
  } state_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Execute-side, memory-side and register-file-side signals of the stage.
interface mem_wb_stage_if
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned AW = AW_DEFAULT
);
  logic                 in_valid;
  logic                 stall;
  logic                 flush;
  logic [MEM_SIG_W-1:0] MEM_signals_in;
  logic [WB_SIG_W-1:0]  WB_signals_in;
  logic [DW-1:0]        ALU_Out;
  logic [DW-1:0]        Rdst_in;
  logic [DW-1:0]        Imm_in;
  logic [AW-1:0]        WA_in;
  logic [DW-1:0]        mem_rdata;
  logic                 mem_ack;
  logic                 mem_req;
  logic                 mem_we;
  logic [DW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata;
  logic                 regWrite;
  logic [AW-1:0]        WA;
  logic [DW-1:0]        WD;
  logic                 busy;
  logic                 mem_err;

  // Environment side: drives execute inputs and memory responses.
  modport master (
    output in_valid, stall, flush, MEM_signals_in, WB_signals_in,
           ALU_Out, Rdst_in, Imm_in, WA_in, mem_rdata, mem_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata, regWrite, WA, WD, busy, mem_err
  );

  // Stage side.
  modport slave (
    input  in_valid, stall, flush, MEM_signals_in, WB_signals_in,
           ALU_Out, Rdst_in, Imm_in, WA_in, mem_rdata, mem_ack,
    output mem_req, mem_we, mem_addr, mem_wdata, regWrite, WA, WD, busy, mem_err
  );
endinterface

// File: rtl/mem_wb_stage_wb_select.sv
// Combinational write-back data selector.
module wb_select
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  wb_sel_e       sel,
  input  logic [DW-1:0] alu,
  input  logic [DW-1:0] rdata,
  input  logic [DW-1:0] imm,
  input  logic [DW-1:0] rdst,
  output logic [DW-1:0] wd_c
);

  // Pick the register-file write data source.
  always_comb begin
    wd_c = alu;
    case (sel)
      WB_SEL_ALU:  wd_c = alu;
      WB_SEL_MEM:  wd_c = rdata;
      WB_SEL_IMM:  wd_c = imm;
      WB_SEL_RDST: wd_c = rdst;
      default:     wd_c = alu;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory access and write-back stage with ack timeout.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DW  = DW_DEFAULT,
  parameter int unsigned AW  = AW_DEFAULT,
  parameter int unsigned TMO = TMO_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  mem_wb_stage_if.slave bus
);

  localparam int unsigned CW = (TMO < 1) ? 1 : $clog2(TMO + 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           mem_req_q, mem_req_d;
  logic           mem_we_q, mem_we_d;
  logic [DW-1:0]  mem_addr_q, mem_addr_d;
  logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
  logic           reg_write_q, reg_write_d;
  logic [AW-1:0]  wa_q, wa_d;
  logic [DW-1:0]  wd_q, wd_d;
  logic           busy_q, busy_d;
  logic           mem_err_q, mem_err_d;

  // Operands latched at acceptance, plus the captured read data.
  logic [DW-1:0]  op_alu_q, op_alu_d;
  logic [DW-1:0]  op_imm_q, op_imm_d;
  logic [DW-1:0]  op_rdst_q, op_rdst_d;
  logic [AW-1:0]  op_wa_q, op_wa_d;
  wb_sel_e        op_sel_q, op_sel_d;
  logic           op_rw_q, op_rw_d;
  logic [DW-1:0]  rdata_q, rdata_d;

  logic           accept_c;
  logic           ack_c;
  logic           is_mem_c;
  logic [DW-1:0]  wd_c;

  // Acceptance, ack qualification and next operand values.
  always_comb begin
    accept_c  = bus.in_valid && !bus.stall && !bus.flush && !busy_q && (state_q != MEM_WAIT);
    ack_c     = (state_q == MEM_WAIT) && bus.mem_ack;
    is_mem_c  = bus.MEM_signals_in[MEM_READ_BIT] || bus.MEM_signals_in[MEM_WRITE_BIT];
    op_alu_d  = op_alu_q;
    op_imm_d  = op_imm_q;
    op_rdst_d = op_rdst_q;
    op_wa_d   = op_wa_q;
    op_sel_d  = op_sel_q;
    op_rw_d   = op_rw_q;
    rdata_d   = rdata_q;
    if (accept_c) begin
      op_alu_d  = bus.ALU_Out;
      op_imm_d  = bus.Imm_in;
      op_rdst_d = bus.Rdst_in;
      op_wa_d   = bus.WA_in;
      op_sel_d  = wb_sel_e'(bus.WB_signals_in[WB_SEL_HI:WB_SEL_LO]);
      op_rw_d   = bus.WB_signals_in[WB_REGWRITE_BIT];
    end
    // A write (including read+write) never captures read data.
    if (ack_c && !mem_we_q) begin
      rdata_d = bus.mem_rdata;
    end
  end

  wb_select #(.DW(DW)) u_wb_select (
    .sel   (op_sel_d),
    .alu   (op_alu_d),
    .rdata (rdata_d),
    .imm   (op_imm_d),
    .rdst  (op_rdst_d),
    .wd_c  (wd_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    reg_write_d = 1'b0;
    wa_d        = wa_q;
    wd_d        = wd_q;
    busy_d      = 1'b0;
    mem_err_d   = mem_err_q;

    case (state_q)
      IDLE, WB: begin
        state_d = IDLE;
        if (accept_c) begin
          if (is_mem_c) begin
            state_d     = MEM_WAIT;
            cnt_d       = '0;
            busy_d      = 1'b1;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.MEM_signals_in[MEM_WRITE_BIT];
            mem_addr_d  = bus.MEM_signals_in[MEM_ADDR_BIT] ? bus.Imm_in : bus.ALU_Out;
            mem_wdata_d = bus.MEM_signals_in[MEM_DATA_BIT] ? bus.ALU_Out : bus.Rdst_in;
          end else begin
            state_d     = WB;
            reg_write_d = op_rw_d;
            wa_d        = op_wa_d;
            wd_d        = wd_c;
          end
        end
      end

      MEM_WAIT: begin
        busy_d = 1'b1;
        if (ack_c) begin
          // Busy stays high through the write-back cycle that follows.
          state_d     = WB;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          reg_write_d = op_rw_q;
          wa_d        = op_wa_q;
          wd_d        = wd_c;
        end else if (cnt_q == CW'(TMO - 1)) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, output and operand registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      reg_write_q <= 1'b0;
      wa_q        <= '0;
      wd_q        <= '0;
      busy_q      <= 1'b0;
      mem_err_q   <= 1'b0;
      op_alu_q    <= '0;
      op_imm_q    <= '0;
      op_rdst_q   <= '0;
      op_wa_q     <= '0;
      op_sel_q    <= WB_SEL_ALU;
      op_rw_q     <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      reg_write_q <= reg_write_d;
      wa_q        <= wa_d;
      wd_q        <= wd_d;
      busy_q      <= busy_d;
      mem_err_q   <= mem_err_d;
      op_alu_q    <= op_alu_d;
      op_imm_q    <= op_imm_d;
      op_rdst_q   <= op_rdst_d;
      op_wa_q     <= op_wa_d;
      op_sel_q    <= op_sel_d;
      op_rw_q     <= op_rw_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.regWrite  = reg_write_q;
  assign bus.WA        = wa_q;
  assign bus.WD        = wd_q;
  assign bus.busy      = busy_q;
  assign bus.mem_err   = mem_err_q;

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameters: DW, default 16, datapath width; AW, default 3, register-file address width; TMO, default 15, memory-ack timeout in cycles.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction presented from execute.
- stall  in  1  hazard-unit stall; blocks acceptance.
- flush  in  1  kills the presented instruction.
- MEM_signals_in  in  4  {memRead, memWrite, memAddress, memData}.
- WB_signals_in  in  3  {regWrite, WBsel[1:0]}.
- ALU_Out  in  DW  execute result.
- Rdst_in  in  DW  destination-register value.
- Imm_in  in  DW  immediate.
- WA_in  in  AW  destination register index.
- mem_rdata  in  DW  data-memory read data.
- mem_ack  in  1  data-memory completion strobe.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  write enable for mem_req.
- mem_addr  out  DW  memory address.
- mem_wdata  out  DW  memory write data.
- regWrite  out  1  register-file write strobe to decode.
- WA  out  AW  register-file write address.
- WD  out  DW  register-file write data.
- busy  out  1  stage cannot accept.
- mem_err  out  1  sticky timeout flag.

Function
REQ-003 SHALL implement states IDLE, MEM_WAIT, WB.
REQ-004 SHALL accept an instruction when in_valid && !stall && !flush && !busy; flush or stall in that cycle SHALL discard it with no side effect.
REQ-005 On acceptance without memRead/memWrite: SHALL go to WB; regWrite/WA/WD SHALL be valid the cycle after acceptance (latency 1).
REQ-006 On acceptance with memRead or memWrite: SHALL go to MEM_WAIT and assert mem_req from the next cycle, holding mem_req, mem_we, mem_addr, mem_wdata stable until mem_ack.
REQ-007 mem_addr SHALL be ALU_Out when memAddress=0, Imm_in when 1; mem_wdata SHALL be Rdst_in when memData=0, ALU_Out when 1.
REQ-008 memRead and memWrite both set SHALL be treated as a write (mem_we=1, no read data captured).
REQ-009 On mem_ack in MEM_WAIT: SHALL capture mem_rdata, deassert mem_req the next cycle, go to WB.
REQ-010 mem_ack outside MEM_WAIT SHALL be ignored.
REQ-011 WD SHALL be selected by WBsel: 00 ALU_Out, 01 captured mem_rdata, 10 Imm_in, 11 Rdst_in (operands latched at acceptance).
REQ-012 In WB, regWrite SHALL pulse exactly one cycle only if latched regWrite=1; otherwise WB SHALL complete with regWrite=0; WB returns to IDLE next cycle.
REQ-013 busy SHALL be 1 in MEM_WAIT and in the cycle of a MEM_WAIT->WB transition, 0 otherwise; an instruction MAY be accepted in WB (back-to-back, one per cycle for non-memory ops).
REQ-014 SHALL count MEM_WAIT cycles with a counter of ceil(log2(TMO+1)) bits; after TMO cycles without ack SHALL set mem_err, drop mem_req, return to IDLE, and not write back.
REQ-015 flush while in MEM_WAIT or WB SHALL NOT abort the in-flight instruction.
REQ-016 WA SHALL never change while regWrite=1.

Reset
REQ-017 rst SHALL force IDLE, clear the counter, and drive mem_req, mem_we, regWrite, busy, mem_err to 0 and mem_addr, mem_wdata, WA, WD to 0 on the next edge, including mid-transaction.
REQ-018 mem_err SHALL clear only on rst.

Structure
REQ-019 The shared package SHALL hold the WBsel encodings, the MEM_signals/WB_signals bit positions, the state enum, and DW/AW defaults.
REQ-020 The WBsel selection SHALL be a combinational sub-module wb_select; all state and capture SHALL live in mem_wb_stage.

Verification
REQ-021 ALU op: ALU_Out=0x0025, WBsel=00, regWrite=1, WA_in=3 -> next cycle regWrite=1, WA=3, WD=0x0025, for one cycle.
REQ-022 Load: memRead=1, memAddress=0, ALU_Out=0x0010, WBsel=01, WA_in=5; ack after 3 cycles with mem_rdata=0xBEEF -> mem_addr=0x0010 held, busy=1, then regWrite=1, WA=5, WD=0xBEEF.
REQ-023 Store: memWrite=1, memData=0, Rdst_in=0x1234, memAddress=1, Imm_in=0x0040, regWrite=0 -> mem_we=1, mem_addr=0x0040, mem_wdata=0x1234; no regWrite after ack.
REQ-024 Timeout: load with no ack -> after 15 MEM_WAIT cycles mem_err=1, mem_req=0, no regWrite; mem_err stays 1 until rst.
REQ-025 Edge cases: in_valid with flush=1 -> no output; rst asserted during MEM_WAIT -> next cycle mem_req=0, busy=0, IDLE; back-to-back ALU ops on consecutive cycles -> regWrite high two consecutive cycles with correct WA/WD.
